// File: rtl/ic_identify_sequencer.sv
// Automatic part-identification sequencer: walks the logical function checker
// through every (tester, gate) candidate, samples pass/fail and reports matches.
module ic_identify_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 100000010,
    parameter int unsigned NUM_GATES     = 6,
    parameter int unsigned STOP_ON_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_pass,
    input  logic       dut_fail,
    output logic [2:0] tester_sel,
    output logic [2:0] gate_sel,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [2:0] found_tester,
    output logic [2:0] found_gate,
    output logic [5:0] match_count,
    output logic [5:0] cand_index
);

    localparam int unsigned NUM_CAND = 1 + 4 * NUM_GATES;
    localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [5:0]       LAST_IDX  = 6'(NUM_CAND - 1);
    localparam logic [2:0]       LAST_GATE = 3'(NUM_GATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       tester_q, tester_d;
    logic [2:0]       gate_q, gate_d;
    logic [5:0]       cand_q, cand_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic [2:0]       ftester_q, ftester_d;
    logic [2:0]       fgate_q, fgate_d;
    logic [5:0]       mcount_q, mcount_d;

    logic match;
    logic stop;

    assign match = dut_pass & ~dut_fail;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tester_d  = tester_q;
        gate_d    = gate_q;
        cand_d    = cand_q;
        busy_d    = busy_q;
        done_d    = done_q;
        found_d   = found_q;
        ftester_d = ftester_q;
        fgate_d   = fgate_q;
        mcount_d  = mcount_q;
        stop      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = SETTLE;
                    cnt_d     = '0;
                    tester_d  = '0;
                    gate_d    = '0;
                    cand_d    = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    found_d   = 1'b0;
                    ftester_d = '0;
                    fgate_d   = '0;
                    mcount_d  = '0;
                end
            end

            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SAMPLE: begin
                if (match) begin
                    if (mcount_q != '1) begin
                        mcount_d = mcount_q + 6'd1;
                    end
                    if (!found_q) begin
                        found_d   = 1'b1;
                        ftester_d = tester_q;
                        fgate_d   = gate_q;
                    end
                end
                stop = (match && (STOP_ON_FIRST != 0)) || (cand_q == LAST_IDX);
                if (stop) begin
                    // Selects are left on the final candidate so the checker keeps showing it.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    cand_d  = cand_q + 6'd1;
                    if (cand_q == '0) begin
                        tester_d = 3'd1;
                        gate_d   = '0;
                    end else if (gate_q == LAST_GATE) begin
                        tester_d = tester_q + 3'd1;
                        gate_d   = '0;
                    end else begin
                        gate_d = gate_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Abort outranks both start and the sample decision; ignored when already idle.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            tester_d  = '0;
            gate_d    = '0;
            cand_d    = '0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            found_d   = 1'b0;
            ftester_d = '0;
            fgate_d   = '0;
            mcount_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tester_q  <= '0;
            gate_q    <= '0;
            cand_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            ftester_q <= '0;
            fgate_q   <= '0;
            mcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tester_q  <= tester_d;
            gate_q    <= gate_d;
            cand_q    <= cand_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            ftester_q <= ftester_d;
            fgate_q   <= fgate_d;
            mcount_q  <= mcount_d;
        end
    end

    assign tester_sel   = tester_q;
    assign gate_sel     = gate_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign found_tester = ftester_q;
    assign found_gate   = fgate_q;
    assign match_count  = mcount_q;
    assign cand_index   = cand_q;

endmodule

// File: tb/tb_ic_identify_sequencer.sv
// Directed bench for ic_identify_sequencer: one stop-on-first instance and one
// scan-all instance, each fed by a small behavioural model of the function checker.
module tb_ic_identify_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort;
    int   mode;
    int   checks = 0;
    int   errors = 0;

    logic [2:0] ts1, gs1, ft1, fg1, ts2, gs2, ft2, fg2;
    logic       busy1, done1, found1, busy2, done2, found2;
    logic [5:0] mc1, ci1, mc2, ci2;
    logic       pass1, fail1, pass2, fail2;
    logic [26:0] obs1, obs2;

    // mode 0: never passes, 1: passes only at (1,2), 2: pass and fail both high
    assign pass1 = (mode == 2) || (mode == 1 && ts1 == 3'd1 && gs1 == 3'd2);
    assign fail1 = (mode == 2) || !pass1;
    assign pass2 = (ts2 == 3'd0 && gs2 == 3'd0) || (ts2 == 3'd2 && gs2 == 3'd1) ||
                   (ts2 == 3'd4 && gs2 == 3'd5);
    assign fail2 = !pass2;

    assign obs1 = {busy1, done1, found1, ft1, fg1, mc1, ci1, ts1, gs1};
    assign obs2 = {busy2, done2, found2, ft2, fg2, mc2, ci2, ts2, gs2};

    ic_identify_sequencer #(.SETTLE_CYCLES(4), .NUM_GATES(6), .STOP_ON_FIRST(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_pass(pass1), .dut_fail(fail1),
        .tester_sel(ts1), .gate_sel(gs1), .busy(busy1), .done(done1), .found(found1),
        .found_tester(ft1), .found_gate(fg1), .match_count(mc1), .cand_index(ci1)
    );

    ic_identify_sequencer #(.SETTLE_CYCLES(4), .NUM_GATES(6), .STOP_ON_FIRST(0)) dut_all (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_pass(pass2), .dut_fail(fail2),
        .tester_sel(ts2), .gate_sel(gs2), .busy(busy2), .done(done2), .found(found2),
        .found_tester(ft2), .found_gate(fg2), .match_count(mc2), .cand_index(ci2)
    );

    function automatic logic [2:0] exp_t(int c);
        if (c == 0) return 3'd0;
        return 3'(1 + (c - 1) / 6);
    endfunction

    function automatic logic [2:0] exp_g(int c);
        if (c == 0) return 3'd0;
        return 3'((c - 1) % 6);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        step; step;
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (obs1 !== 27'h0) begin errors++; $display("FAIL reset_dut: got %h expected %h", obs1, 27'h0); end
        checks++;
        if (obs2 !== 27'h0) begin errors++; $display("FAIL reset_dut_all: got %h expected %h", obs2, 27'h0); end
    endtask

    task automatic test_first_match;
        logic [26:0] exp;
        mode = 1;
        pulse_start;
        checks++;
        if (busy1 !== 1'b1 || ci1 !== 6'd0) begin
            errors++; $display("FAIL start_load: busy %b cand %0d expected busy 1 cand 0", busy1, ci1);
        end
        for (int k = 1; k < 20; k++) begin
            step;
            checks++;
            if (ci1 !== 6'(k / 5) || ts1 !== exp_t(k / 5) || gs1 !== exp_g(k / 5) || busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL first_seq k=%0d: cand %0d sel (%0d,%0d) busy %b done %b expected cand %0d sel (%0d,%0d) busy 1 done 0",
                         k, ci1, ts1, gs1, busy1, done1, k / 5, exp_t(k / 5), exp_g(k / 5));
            end
        end
        step;
        exp = {1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 6'd1, 6'd3, 3'd1, 3'd2};
        checks++;
        if (obs1 !== exp) begin errors++; $display("FAIL first_done: got %h expected %h", obs1, exp); end
    endtask

    task automatic test_abort_done;
        abort = 1'b1;
        step;
        abort = 1'b0;
        checks++;
        if (obs1 !== 27'h0) begin errors++; $display("FAIL abort_in_done: got %h expected %h", obs1, 27'h0); end
    endtask

    task automatic test_scan_all;
        logic [26:0] exp;
        mode = 0;
        do_reset;
        pulse_start;
        for (int k = 1; k < 125; k++) begin
            step;
            checks++;
            if (ci1 !== 6'(k / 5) || ts1 !== exp_t(k / 5) || gs1 !== exp_g(k / 5) || done1 !== 1'b0 || done2 !== 1'b0) begin
                errors++;
                $display("FAIL scan_seq k=%0d: cand %0d sel (%0d,%0d) done %b/%b expected cand %0d sel (%0d,%0d) done 0/0",
                         k, ci1, ts1, gs1, done1, done2, k / 5, exp_t(k / 5), exp_g(k / 5));
            end
        end
        step;
        exp = {1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 6'd0, 6'd24, 3'd4, 3'd5};
        checks++;
        if (obs1 !== exp) begin errors++; $display("FAIL scan_nomatch_done: got %h expected %h", obs1, exp); end
        exp = {1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 6'd3, 6'd24, 3'd4, 3'd5};
        checks++;
        if (obs2 !== exp) begin errors++; $display("FAIL scan_all_count: got %h expected %h", obs2, exp); end
    endtask

    task automatic test_both_high;
        logic [26:0] exp;
        mode = 2;
        do_reset;
        pulse_start;
        repeat (124) step;
        checks++;
        if (done1 !== 1'b0) begin errors++; $display("FAIL both_high_early: done %b expected 0", done1); end
        step;
        exp = {1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 6'd0, 6'd24, 3'd4, 3'd5};
        checks++;
        if (obs1 !== exp) begin errors++; $display("FAIL both_high_done: got %h expected %h", obs1, exp); end
    endtask

    task automatic test_abort_mid;
        logic [26:0] exp;
        mode = 0;
        do_reset;
        pulse_start;
        repeat (36) step;
        checks++;
        if (ci1 !== 6'd7 || ts1 !== 3'd2 || gs1 !== 3'd0 || mc2 !== 6'd1) begin
            errors++; $display("FAIL pre_abort: cand %0d sel (%0d,%0d) count2 %0d expected cand 7 sel (2,0) count2 1", ci1, ts1, gs1, mc2);
        end
        abort = 1'b1;
        step;
        abort = 1'b0;
        checks++;
        if (obs1 !== 27'h0) begin errors++; $display("FAIL abort_mid: got %h expected %h", obs1, 27'h0); end
        checks++;
        if (obs2 !== 27'h0) begin errors++; $display("FAIL abort_mid_all: got %h expected %h", obs2, 27'h0); end
        mode = 1;
        pulse_start;
        checks++;
        if (ci1 !== 6'd0 || mc1 !== 6'd0 || busy1 !== 1'b1 || mc2 !== 6'd0) begin
            errors++; $display("FAIL restart: cand %0d count %0d busy %b count2 %0d expected 0 0 1 0", ci1, mc1, busy1, mc2);
        end
        repeat (20) step;
        exp = {1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 6'd1, 6'd3, 3'd1, 3'd2};
        checks++;
        if (obs1 !== exp) begin errors++; $display("FAIL restart_done: got %h expected %h", obs1, exp); end
    endtask

    task automatic test_start_ignored_and_rst;
        mode = 0;
        do_reset;
        pulse_start;
        start = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            step;
            checks++;
            if (ci1 !== 6'(k / 5) || busy1 !== 1'b1) begin
                errors++; $display("FAIL start_ignored k=%0d: cand %0d busy %b expected cand %0d busy 1", k, ci1, busy1, k / 5);
            end
        end
        // Both instances now sit in SAMPLE for candidate 8.
        rst = 1'b1;
        step;
        checks++;
        if (obs1 !== 27'h0) begin errors++; $display("FAIL rst_in_sample: got %h expected %h", obs1, 27'h0); end
        checks++;
        if (obs2 !== 27'h0) begin errors++; $display("FAIL rst_in_sample_all: got %h expected %h", obs2, 27'h0); end
        rst = 1'b0;
        start = 1'b0;
        step;
        checks++;
        if (obs1 !== 27'h0) begin errors++; $display("FAIL idle_after_rst: got %h expected %h", obs1, 27'h0); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0;
        test_reset;
        test_first_match;
        test_abort_done;
        test_scan_all;
        test_both_high;
        test_abort_mid;
        test_start_ignored_and_rst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
